// File: rtl/cache_pkg.sv
// cache_pkg
//   Shared types and line-geometry constants for the cache/backing-memory
//   arbiter. No ports.
//   - arb_state_e : transfer sequencer states
//   - requester_e : which cache owns the current transfer
//   - LINE_BYTES / OFFSET_W : geometry of the default 4-word line
//   - offset_w()  : byte-offset width for any WORDS_PER_LINE
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IC_FILL = 3'd1,
    DC_FILL = 3'd2,
    DC_WB   = 3'd3,
    RESP    = 3'd4
  } arb_state_e;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } requester_e;

  localparam int WORDS_PER_LINE_DFLT = 4;
  localparam int WORD_BYTES          = 4;
  localparam int LINE_BYTES          = WORDS_PER_LINE_DFLT * WORD_BYTES;
  localparam int OFFSET_W            = $clog2(LINE_BYTES);

  // Number of low address bits covered by one line of wpl words.
  function automatic int offset_w(input int wpl);
    return $clog2(wpl * WORD_BYTES);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-input round-robin arbiter with a last-grant register.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     i_req_ic, i_req_dc  request lines
//     i_update            record the current grant as the last grant
//     o_gnt_ic, o_gnt_dc  one-hot (or zero) grant, combinational
//   Last grant resets to the I-cache so the D-cache wins the first tie.
module rr_arb2
  import cache_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_ic,
  input  logic i_req_dc,
  input  logic i_update,
  output logic o_gnt_ic,
  output logic o_gnt_dc
);

  requester_e r_last;
  logic       w_gnt_dc;

  // D-cache wins when alone, or on a tie when the I-cache had the last grant.
  assign w_gnt_dc = i_req_dc & (~i_req_ic | (r_last == REQ_IC));
  assign o_gnt_dc = w_gnt_dc;
  assign o_gnt_ic = i_req_ic & ~w_gnt_dc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= REQ_IC;
    end else if (i_update) begin
      r_last <= w_gnt_dc ? REQ_DC : REQ_IC;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Sequences line transfers between the I-cache, the D-cache and one
//   single-port backing memory. Round-robin grant, then a WORDS_PER_LINE
//   beat burst, then a one-cycle done pulse to the owning cache.
//   Ports:
//     clk, rst_n                      clock, asynchronous active-low reset
//     i_ic_req/i_ic_addr              I-cache fill request (level) and address
//     o_ic_rvalid/o_ic_rdata/o_ic_word_idx/o_ic_done   I-cache fill beats, done
//     i_dc_req/i_dc_we/i_dc_addr      D-cache request, writeback flag, address
//     i_dc_wdata                      writeback word selected by o_dc_word_idx
//     o_dc_rvalid/o_dc_rdata/o_dc_word_idx/o_dc_done   D-cache beats, done
//     o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata        memory beat request
//     i_mem_ack/i_mem_rdata           memory beat completion and read data
//     o_dbg_state                     current sequencer state (arb_state_e)
//   Handshakes:
//     cache side  - req is a level held until the matching done pulse; req,
//                   addr and dc_we are sampled only in IDLE at the grant edge.
//     memory side - a beat is in flight while mem_req=1; it completes on the
//                   rising edge where mem_ack=1 (read data valid that cycle).
//                   mem_addr/mem_we/mem_wdata are held until then; mem_ack
//                   with mem_req=0 is ignored.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DFLT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_ic_req,
  input  logic [ADDR_WIDTH-1:0]             i_ic_addr,
  output logic                              o_ic_rvalid,
  output logic [DATA_WIDTH-1:0]             o_ic_rdata,
  output logic [$clog2(WORDS_PER_LINE)-1:0] o_ic_word_idx,
  output logic                              o_ic_done,
  input  logic                              i_dc_req,
  input  logic                              i_dc_we,
  input  logic [ADDR_WIDTH-1:0]             i_dc_addr,
  input  logic [DATA_WIDTH-1:0]             i_dc_wdata,
  output logic                              o_dc_rvalid,
  output logic [DATA_WIDTH-1:0]             o_dc_rdata,
  output logic [$clog2(WORDS_PER_LINE)-1:0] o_dc_word_idx,
  output logic                              o_dc_done,
  output logic                              o_mem_req,
  output logic                              o_mem_we,
  output logic [ADDR_WIDTH-1:0]             o_mem_addr,
  output logic [DATA_WIDTH-1:0]             o_mem_wdata,
  input  logic                              i_mem_ack,
  input  logic [DATA_WIDTH-1:0]             i_mem_rdata,
  output logic [2:0]                        o_dbg_state
);

  localparam int IDX_W  = $clog2(WORDS_PER_LINE);
  localparam int LOFF_W = (WORDS_PER_LINE == WORDS_PER_LINE_DFLT) ? OFFSET_W
                                                                  : offset_w(WORDS_PER_LINE);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << LOFF_W) - ADDR_WIDTH'(1));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  arb_state_e            r_state;
  requester_e            r_owner;
  logic [IDX_W-1:0]      r_idx;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic                  r_ic_done;
  logic                  r_dc_done;

  logic                  w_gnt_ic;
  logic                  w_gnt_dc;
  logic                  w_arb_update;
  logic [ADDR_WIDTH-1:0] w_line_base;
  logic                  w_in_ic_fill;
  logic                  w_in_dc_fill;
  logic                  w_in_dc_xfer;

  // Last-grant only moves when a grant is actually issued from IDLE.
  assign w_arb_update = (r_state == IDLE) & (i_ic_req | i_dc_req);

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req_ic (i_ic_req),
    .i_req_dc (i_dc_req),
    .i_update (w_arb_update),
    .o_gnt_ic (w_gnt_ic),
    .o_gnt_dc (w_gnt_dc)
  );

  assign w_line_base = (w_gnt_dc ? i_dc_addr : i_ic_addr) & LINE_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= REQ_IC;
      r_idx     <= '0;
      r_base    <= '0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_ic_done <= 1'b0;
      r_dc_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_ic | w_gnt_dc) begin
            r_idx     <= '0;
            r_base    <= w_line_base;
            r_mem_req <= 1'b1;
            if (w_gnt_dc) begin
              r_owner  <= REQ_DC;
              r_mem_we <= i_dc_we;
              r_state  <= i_dc_we ? DC_WB : DC_FILL;
            end else begin
              r_owner  <= REQ_IC;
              r_mem_we <= 1'b0;
              r_state  <= IC_FILL;
            end
          end
        end
        IC_FILL, DC_FILL, DC_WB: begin
          if (i_mem_ack) begin
            r_idx <= r_idx + IDX_W'(1);
            if (r_idx == LAST_IDX) begin
              r_state   <= RESP;
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
              r_ic_done <= (r_owner == REQ_IC);
              r_dc_done <= (r_owner == REQ_DC);
            end
          end
        end
        RESP: begin
          r_ic_done <= 1'b0;
          r_dc_done <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_in_ic_fill = (r_state == IC_FILL);
  assign w_in_dc_fill = (r_state == DC_FILL);
  assign w_in_dc_xfer = (r_state == DC_FILL) | (r_state == DC_WB);

  // Fill beats are presented in the ack cycle itself; data is zeroed otherwise
  // so an idle requester sees all-zero outputs.
  assign o_ic_rvalid   = w_in_ic_fill & i_mem_ack;
  assign o_dc_rvalid   = w_in_dc_fill & i_mem_ack;
  assign o_ic_rdata    = o_ic_rvalid ? i_mem_rdata : '0;
  assign o_dc_rdata    = o_dc_rvalid ? i_mem_rdata : '0;
  assign o_ic_word_idx = w_in_ic_fill ? r_idx : '0;
  assign o_dc_word_idx = w_in_dc_xfer ? r_idx : '0;
  assign o_ic_done     = r_ic_done;
  assign o_dc_done     = r_dc_done;

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_req ? (r_base + (ADDR_WIDTH'(r_idx) << 2)) : '0;
  assign o_mem_wdata = r_mem_we ? i_dc_wdata : '0;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
//   Directed bench for cache_mem_arbiter: reset, single fill, ties,
//   slow-ack writeback, mid-burst reset, back-to-back D-cache transfers.
module tb_cache_mem_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int WPL = 4;
  localparam int IW  = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_IC_FILL = 3'd1;
  localparam logic [2:0] ST_DC_FILL = 3'd2;
  localparam logic [2:0] ST_DC_WB   = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          ic_req, dc_req, dc_we, mem_ack;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [DW-1:0] dc_wdata, mem_rdata, wdata_base;
  logic          ic_rvalid, ic_done, dc_rvalid, dc_done, mem_req, mem_we;
  logic [DW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] ic_word_idx, dc_word_idx;
  logic [2:0]    dbg_state;

  // D-cache supplies the writeback word for the index the arbiter selects.
  assign dc_wdata = wdata_base + DW'(dc_word_idx);

  cache_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_LINE(WPL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_ic_req      (ic_req),
    .i_ic_addr     (ic_addr),
    .o_ic_rvalid   (ic_rvalid),
    .o_ic_rdata    (ic_rdata),
    .o_ic_word_idx (ic_word_idx),
    .o_ic_done     (ic_done),
    .i_dc_req      (dc_req),
    .i_dc_we       (dc_we),
    .i_dc_addr     (dc_addr),
    .i_dc_wdata    (dc_wdata),
    .o_dc_rvalid   (dc_rvalid),
    .o_dc_rdata    (dc_rdata),
    .o_dc_word_idx (dc_word_idx),
    .o_dc_done     (dc_done),
    .o_mem_req     (mem_req),
    .o_mem_we      (mem_we),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .i_mem_ack     (mem_ack),
    .i_mem_rdata   (mem_rdata),
    .o_dbg_state   (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " ctrl"}, 32'({mem_req, mem_we, ic_rvalid, ic_done, dc_rvalid, dc_done,
                             ic_word_idx, dc_word_idx}), 32'h0);
    chk({tag, " mem_addr"}, mem_addr, 32'h0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, " ic_rdata"}, ic_rdata, 32'h0);
    chk({tag, " dc_rdata"}, dc_rdata, 32'h0);
    chk({tag, " state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Called #1 after the grant edge. Drives nbeats acks, each preceded by
  // 'waits' cycles of mem_ack=0. A full burst ends with the RESP cycle checked.
  task automatic run_burst(input string tag, input bit is_dc, input bit we,
                           input logic [31:0] base, input int waits, input int nbeats,
                           input logic [31:0] rbase);
    logic [31:0] e_addr, e_wdata, e_rd;
    bit          e_ic_rv, e_dc_rv;
    for (int b = 0; b < nbeats; b++) begin
      e_addr  = base + 32'(4 * b);
      e_wdata = we ? (wdata_base + 32'(b)) : 32'h0;
      for (int w = 0; w < waits; w++) begin
        mem_ack = 1'b0;
        #1;
        chk({tag, " hold req"}, 32'(mem_req), 32'h1);
        chk({tag, " hold addr"}, mem_addr, e_addr);
        chk({tag, " hold we"}, 32'(mem_we), 32'(we));
        chk({tag, " hold wdata"}, mem_wdata, e_wdata);
        chk({tag, " hold rvalid"}, 32'({ic_rvalid, dc_rvalid}), 32'h0);
        tick();
      end
      mem_ack   = 1'b1;
      mem_rdata = rbase + 32'(b);
      #1;
      e_ic_rv = !is_dc;
      e_dc_rv = is_dc && !we;
      e_rd    = rbase + 32'(b);
      chk({tag, " req"}, 32'(mem_req), 32'h1);
      chk({tag, " addr"}, mem_addr, e_addr);
      chk({tag, " we"}, 32'(mem_we), 32'(we));
      chk({tag, " wdata"}, mem_wdata, e_wdata);
      chk({tag, " rvalid"}, 32'({ic_rvalid, dc_rvalid}), 32'({e_ic_rv, e_dc_rv}));
      chk({tag, " ic_rdata"}, ic_rdata, e_ic_rv ? e_rd : 32'h0);
      chk({tag, " dc_rdata"}, dc_rdata, e_dc_rv ? e_rd : 32'h0);
      chk({tag, " ic_idx"}, 32'(ic_word_idx), is_dc ? 32'h0 : 32'(b));
      chk({tag, " dc_idx"}, 32'(dc_word_idx), is_dc ? 32'(b) : 32'h0);
      chk({tag, " early done"}, 32'({ic_done, dc_done}), 32'h0);
      tick();
      mem_ack = 1'b0;
    end
    if (nbeats == WPL) begin
      #1;
      chk({tag, " resp state"}, 32'(dbg_state), 32'(ST_RESP));
      chk({tag, " done"}, 32'({ic_done, dc_done}), 32'({!is_dc, is_dc}));
      chk({tag, " resp mem_req"}, 32'(mem_req), 32'h0);
      chk({tag, " resp rvalid"}, 32'({ic_rvalid, dc_rvalid}), 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ic_req = 0; dc_req = 0; dc_we = 0; mem_ack = 0;
    ic_addr = '0; dc_addr = '0; mem_rdata = '0; wdata_base = 32'hA0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_all_zero("reset async");
    tick();
    tick();
    check_all_zero("reset held");
    rst_n = 1'b1;
    tick();

    // Single I-cache fill, zero-wait acks.
    ic_addr = 32'h0000_1234;
    ic_req  = 1'b1;
    #1;
    chk("t1 no req before grant", 32'(mem_req), 32'h0);
    tick();
    chk("t1 grant state", 32'(dbg_state), 32'(ST_IC_FILL));
    run_burst("t1", 1'b0, 1'b0, 32'h0000_1230, 0, WPL, 32'h1100_0000);
    ic_req = 1'b0;
    tick();
    chk("t1 done one cycle", 32'(ic_done), 32'h0);
    chk("t1 back idle", 32'(dbg_state), 32'(ST_IDLE));

    // Tie: D-cache first, then I-cache, then tie again -> D-cache.
    ic_addr = 32'h0000_5000;
    dc_addr = 32'h0000_6000;
    dc_we   = 1'b0;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    tick();
    chk("t2 tie grant dc", 32'(dbg_state), 32'(ST_DC_FILL));
    run_burst("t2 dc", 1'b1, 1'b0, 32'h0000_6000, 0, WPL, 32'h2200_0000);
    dc_req = 1'b0;
    tick();
    chk("t2 idle after dc", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    chk("t2 ic granted", 32'(dbg_state), 32'(ST_IC_FILL));
    run_burst("t2 ic", 1'b0, 1'b0, 32'h0000_5000, 0, WPL, 32'h3300_0000);
    ic_req = 1'b0;
    tick();
    ic_addr = 32'h0000_5010;
    dc_addr = 32'h0000_6040;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    tick();
    chk("t2 second tie dc", 32'(dbg_state), 32'(ST_DC_FILL));
    run_burst("t2 dc2", 1'b1, 1'b0, 32'h0000_6040, 0, WPL, 32'h4400_0000);
    dc_req = 1'b0;
    ic_req = 1'b0;
    tick();

    // Writeback with acks every third cycle.
    wdata_base = 32'hA0;
    dc_addr    = 32'h0000_2000;
    dc_we      = 1'b1;
    dc_req     = 1'b1;
    tick();
    chk("t3 grant wb", 32'(dbg_state), 32'(ST_DC_WB));
    run_burst("t3 wb", 1'b1, 1'b1, 32'h0000_2000, 2, WPL, 32'hDEAD_BEEF);
    dc_req = 1'b0;
    dc_we  = 1'b0;
    tick();
    chk("t3 done once", 32'(dc_done), 32'h0);
    chk("t3 idle", 32'(dbg_state), 32'(ST_IDLE));

    // Stray ack with nothing in flight.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle ack state", 32'(dbg_state), 32'(ST_IDLE));
    chk("idle ack mem_req", 32'(mem_req), 32'h0);

    // Reset after the second beat of an I-cache fill.
    ic_addr = 32'h0000_7008;
    ic_req  = 1'b1;
    tick();
    chk("t4 grant", 32'(dbg_state), 32'(ST_IC_FILL));
    run_burst("t4 pre", 1'b0, 1'b0, 32'h0000_7000, 0, 2, 32'h5500_0000);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("t4 async reset");
    tick();
    tick();
    chk("t4 no done", 32'(ic_done), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("t4 regrant", 32'(dbg_state), 32'(ST_IC_FILL));
    run_burst("t4 restart", 1'b0, 1'b0, 32'h0000_7000, 0, WPL, 32'h6600_0000);
    ic_req = 1'b0;
    tick();

    // Back-to-back D-cache writeback then fill.
    wdata_base = 32'hB0;
    dc_addr    = 32'h0000_3000;
    dc_we      = 1'b1;
    dc_req     = 1'b1;
    tick();
    chk("t5 grant wb", 32'(dbg_state), 32'(ST_DC_WB));
    run_burst("t5 wb", 1'b1, 1'b1, 32'h0000_3000, 0, WPL, 32'h0);
    dc_req = 1'b0;
    tick();
    chk("t5 gap mem_req", 32'(mem_req), 32'h0);
    dc_addr = 32'h0000_4000;
    dc_we   = 1'b0;
    dc_req  = 1'b1;
    mem_ack = 1'b1;
    #1;
    chk("t5 idle ack rvalid", 32'({ic_rvalid, dc_rvalid}), 32'h0);
    chk("t5 idle ack mem_req", 32'(mem_req), 32'h0);
    tick();
    mem_ack = 1'b0;
    chk("t5 fill grant", 32'(dbg_state), 32'(ST_DC_FILL));
    run_burst("t5 fill", 1'b1, 1'b0, 32'h0000_4000, 0, WPL, 32'h7700_0000);
    dc_req = 1'b0;
    tick();
    check_all_zero("t5 end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
